imm_gen_pipe: RTL and testbench

//  Pipelined, multi-lane immediate generator for the decode stage. Each cycle it accepts a bundle of

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/imm_decode_lane.sv | 79 +++++++
 rtl/imm_gen_pipe.sv | 110 +++++++++++
 tb/tb_imm_gen_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared decode types: immediate format codes, RV opcode constants and the
// occupancy states of the immediate-generator output buffer.
package cpu_types_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_Z   = 3'd6,
        FMT_BAD = 3'd7
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_lane.sv
// Combinational immediate decode for a single 32-bit instruction.
// IMM_GEN_CSR_EN selects CSR-aware decode of SYSTEM (zimm / CSR address).
module imm_decode_lane
    import cpu_types_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o,
    output logic            illegal_o
);

    logic        s;
    logic signed [31:0] imm32;

    assign s = inst_i[31];

    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_BAD;
        illegal_o = 1'b1;
        case (inst_i[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                // Shift immediates keep the raw field; the ALU masks shamt.
                imm32     = {{20{s}}, inst_i[31:20]};
                fmt_o     = FMT_I;
                illegal_o = 1'b0;
            end
            OPC_STORE: begin
                imm32     = {{20{s}}, inst_i[31:25], inst_i[11:7]};
                fmt_o     = FMT_S;
                illegal_o = 1'b0;
            end
            OPC_BRANCH: begin
                imm32     = {{19{s}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
                fmt_o     = FMT_B;
                illegal_o = 1'b0;
            end
            OPC_JAL: begin
                imm32     = {{11{s}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
                fmt_o     = FMT_J;
                illegal_o = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32     = {inst_i[31:12], 12'b0};
                fmt_o     = FMT_U;
                illegal_o = 1'b0;
            end
            OPC_OP: begin
                fmt_o     = FMT_R;
                illegal_o = 1'b0;
            end
            OPC_SYSTEM: begin
                illegal_o = 1'b0;
`ifdef IMM_GEN_CSR_EN
                if (inst_i[14]) begin
                    imm32 = {27'b0, inst_i[19:15]};
                    fmt_o = FMT_Z;
                end else begin
                    imm32 = {{20{s}}, inst_i[31:20]};
                    fmt_o = FMT_I;
                end
`else
                fmt_o = FMT_R;
`endif
            end
            default: begin
                imm32     = '0;
                fmt_o     = FMT_BAD;
                illegal_o = 1'b1;
            end
        endcase
    end

    // imm32 is signed, so widening replicates bit 31 (zimm has bit 31 clear).
    assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane registered immediate generator with a 2-entry skid buffer.
// Build option IMM_GEN_CSR_EN is forwarded to each imm_decode_lane.
module imm_gen_pipe
    import cpu_types_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*XLEN-1:0] out_imm,
    output logic [LANES*3-1:0]    out_fmt,
    output logic [LANES-1:0]      out_illegal
);

    localparam int IW = LANES * XLEN;
    localparam int FW = LANES * 3;
    localparam int BW = IW + FW + LANES;

    logic [IW-1:0]    dec_imm;
    logic [FW-1:0]    dec_fmt;
    logic [LANES-1:0] dec_ill;
    logic [BW-1:0]    dec_bundle;

    skid_state_t      state_q, state_d;
    logic [BW-1:0]    out_q, out_d;
    logic [BW-1:0]    skid_q, skid_d;
    logic             accept, pop;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            imm_fmt_t lane_fmt;

            imm_decode_lane #(
                .XLEN (XLEN)
            ) u_lane (
                .inst_i    (in_inst[32*gi +: 32]),
                .imm_o     (dec_imm[XLEN*gi +: XLEN]),
                .fmt_o     (lane_fmt),
                .illegal_o (dec_ill[gi])
            );

            assign dec_fmt[3*gi +: 3] = lane_fmt;
        end
    endgenerate

    assign dec_bundle = {dec_imm, dec_fmt, dec_ill};

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {out_imm, out_fmt, out_illegal} = out_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = dec_bundle;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        out_d = dec_bundle;
                    end else if (accept) begin
                        skid_d  = dec_bundle;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: XLEN=64/LANES=2 instance plus an XLEN=32/LANES=1 instance on lane 0.
module tb_imm_gen_pipe;

    logic         CLK = 1'b0;
    logic         nRST, flush, in_valid, out_ready;
    logic [63:0]  in_inst;

    logic         w_in_ready, w_out_valid;
    logic [127:0] w_out_imm;
    logic [5:0]   w_out_fmt;
    logic [1:0]   w_out_illegal;

    logic         n_in_ready, n_out_valid;
    logic [31:0]  n_out_imm;
    logic [2:0]   n_out_fmt;
    logic [0:0]   n_out_illegal;

    typedef struct packed {
        logic [127:0] imm;
        logic [5:0]   fmt;
        logic [1:0]   ill;
    } exp_t;

    exp_t   sb[$];
    int     tests = 0;
    int     fails = 0;
    int     pops  = 0;

    imm_gen_pipe #(.XLEN(64), .LANES(2)) dut_w (
        .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_inst(in_inst), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_imm(w_out_imm), .out_fmt(w_out_fmt), .out_illegal(w_out_illegal)
    );

    imm_gen_pipe #(.XLEN(32), .LANES(1)) dut_n (
        .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_inst(in_inst[31:0]), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_imm(n_out_imm), .out_fmt(n_out_fmt), .out_illegal(n_out_illegal)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the consumer takes a bundle.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (nRST && w_out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got imm %0h, expected no bundle", w_out_imm);
            end else begin
                e = sb.pop_front();
                pops++;
                $display("[TB] pop %0d imm=%h fmt=%h ill=%b", pops, w_out_imm, w_out_fmt, w_out_illegal);
                chk("imm64",   w_out_imm,     e.imm);
                chk("fmt64",   w_out_fmt,     e.fmt);
                chk("ill64",   w_out_illegal, e.ill);
                chk("valid32", n_out_valid,   1);
                chk("imm32",   n_out_imm,     e.imm[31:0]);
                chk("fmt32",   n_out_fmt,     e.fmt[2:0]);
                chk("ill32",   n_out_illegal, e.ill[0]);
            end
        end
    end

    // Outputs must hold while stalled.
    logic         hold = 1'b0;
    logic [127:0] hold_imm;
    always @(negedge CLK) begin
        if (hold && nRST && w_out_valid)
            chk("hold_stable", w_out_imm, hold_imm);
        hold     = nRST && w_out_valid && !out_ready && !flush;
        hold_imm = w_out_imm;
    end

    task automatic send(input logic [31:0] i0, input logic [63:0] e0, input logic [2:0] f0, input logic l0,
                        input logic [31:0] i1, input logic [63:0] e1, input logic [2:0] f1, input logic l1);
        int n = 0;
        in_valid = 1'b1;
        in_inst  = {i1, i0};
        @(negedge CLK);
        while (!w_in_ready && n < 50) begin
            n++;
            @(negedge CLK);
        end
        if (!w_in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", w_in_ready);
        end else begin
            sb.push_back('{imm: {e1, e0}, fmt: {f1, f0}, ill: {l1, l0}});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_inst  = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int base;
        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = '0;
        #12;
        chk("rst_out_valid", w_out_valid, 0);
        chk("rst_in_ready",  w_in_ready,  1);
        chk("rst_out_imm",   w_out_imm,   0);
        chk("rst_out_fmt",   w_out_fmt,   0);
        chk("rst_out_ill",   w_out_illegal, 0);
        chk("rst_valid32",   n_out_valid, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Directed decode vectors, back-to-back.
        send(32'hFFF00093, ONES, 3'd1, 1'b0, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
        chk("latency_1cycle", w_out_valid, 1);
        send(32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 1'b0, 32'h12345037, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
        send(32'h00112623, 64'h0000_0000_0000_000C, 3'd2, 1'b0, 32'h80000037, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        send(32'h002081B3, 64'h0,                   3'd0, 1'b0, 32'hFFC42503, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);
        send(32'h4050D093, 64'h0000_0000_0000_0405, 3'd1, 1'b0, 32'h00509093, 64'h5,                   3'd1, 1'b0);
        send(32'h000080E7, 64'h0,                   3'd1, 1'b0, 32'hFFFFF517, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 1'b0);
`ifdef IMM_GEN_CSR_EN
        send(32'h300FD073, 64'h1F,  3'd6, 1'b0, 32'h0000007F, 64'h0, 3'd7, 1'b1);
        send(32'h30002573, 64'h300, 3'd1, 1'b0, 32'h00100073, 64'h1, 3'd1, 1'b0);
`else
        send(32'h300FD073, 64'h0,   3'd0, 1'b0, 32'h0000007F, 64'h0, 3'd7, 1'b1);
        send(32'h30002573, 64'h0,   3'd0, 1'b0, 32'h00100073, 64'h0, 3'd0, 1'b0);
`endif
        idle();
        drain();

        // Backpressure: five lui bundles, consumer stalled for three cycles.
        base = pops;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send(32'h12345037, 64'h1234_5000, 3'd4, 1'b0,
                         (32'(k) << 12) | 32'h37, 64'(k) << 12, 3'd4, 1'b0);
                idle();
            end
            begin
                @(posedge CLK);
                @(posedge CLK);
                #2;
                chk("bp_in_ready_low",   w_in_ready, 0);
                chk("bp_in_ready32_low", n_in_ready, 0);
                chk("bp_out_valid",      w_out_valid, 1);
                @(posedge CLK);
                #2;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", pops - base, 5);
        chk("bp_idle_valid", w_out_valid, 0);

        // Flush while FULL with a simultaneous input.
        out_ready = 1'b0;
        send(32'h00112623, 64'hC, 3'd2, 1'b0, 32'h0, 64'h0, 3'd7, 1'b1);
        send(32'hFFF00093, ONES,  3'd1, 1'b0, 32'h0, 64'h0, 3'd7, 1'b1);
        chk("pre_flush_full", w_in_ready, 0);
        in_valid = 1'b1;
        in_inst  = {32'h12345037, 32'h12345037};
        flush    = 1'b1;
        sb.delete();
        @(posedge CLK);
        #1;
        flush = 1'b0;
        idle();
        chk("flush_out_valid", w_out_valid, 0);
        chk("flush_in_ready",  w_in_ready,  1);
        chk("flush_valid32",   n_out_valid, 0);
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("flush_dropped", w_out_valid, 0);
        send(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 32'h002081B3, 64'h0, 3'd0, 1'b0);
        idle();
        drain();

        // Asynchronous reset mid-stream while FULL.
        out_ready = 1'b0;
        send(32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 1'b0, 32'h0, 64'h0, 3'd7, 1'b1);
        send(32'hFFF00093, ONES, 3'd1, 1'b0, 32'h0, 64'h0, 3'd7, 1'b1);
        idle();
        chk("pre_rst_valid", w_out_valid, 1);
        #3;
        nRST = 1'b0;
        sb.delete();
        #1;
        chk("arst_out_valid", w_out_valid, 0);
        chk("arst_in_ready",  w_in_ready,  1);
        chk("arst_out_imm",   w_out_imm,   0);
        chk("arst_valid32",   n_out_valid, 0);
        chk("arst_imm32",     n_out_imm,   0);
        @(negedge CLK);
        nRST = 1'b1;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        send(32'h12345037, 64'h1234_5000, 3'd4, 1'b0, 32'h0000007F, 64'h0, 3'd7, 1'b1);
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
